// File: rtl/dm_access_unit_if.sv
// Word-organised data memory bus between the access unit (master) and the memory (slave).
// Read data is combinational from the address.
interface dm_access_unit_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;
  logic [31:0] mem_pc;

  modport master (output mem_addr, mem_wd, mem_we, mem_pc, input mem_rd);
  modport slave  (input mem_addr, mem_wd, mem_we, mem_pc, output mem_rd);
endinterface

// File: rtl/dm_access_unit.sv
// Load/store access unit: byte/halfword/word accesses over a word-only memory,
// with read-modify-write for sub-word stores and sign/zero-extended loads.
//
// state | meaning
// IDLE  | ready; accept and latch a request
// READ  | register memory word; extract load lane or merge store lane
// WRITE | mem_we high for this cycle only
// DONE  | done pulse, addr_err reflects the rejected flag
module dm_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  output logic        ready,
  output logic        done,
  output logic [31:0] rdata,
  output logic        addr_err,
  dm_access_unit_if.master mem
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        we_q;
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] addr_q;
  logic [31:0] wd_q;
  logic [31:0] pc_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        req_err;
  logic [4:0]  lane_sh;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;

  assign req_err = (size == 2'b11) ||
                   (size == 2'b01 && addr[0]) ||
                   (size == 2'b10 && addr[1:0] != 2'b00);

  assign lane_sh = {addr_q[1:0], 3'b000};

  always_comb begin
    shifted   = mem.mem_rd >> lane_sh;
    load_val  = mem.mem_rd;
    lane_mask = 32'hFFFF_FFFF;
    case (size_q)
      2'b00: begin
        load_val  = sext_q ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
        lane_mask = 32'h0000_00FF << lane_sh;
      end
      2'b01: begin
        load_val  = sext_q ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
        lane_mask = 32'h0000_FFFF << lane_sh;
      end
      default: ;
    endcase
    // Store data arrives in the low lane; shift it up to the addressed lane.
    merged = (mem.mem_rd & ~lane_mask) | ((wd_q << lane_sh) & lane_mask);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      pc_q    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          we_q   <= we;
          size_q <= size;
          sext_q <= sign_ext;
          addr_q <= addr;
          wd_q   <= wdata;
          pc_q   <= pc;
          err_q  <= req_err;
          if (req_err)                   state <= DONE;
          else if (we && size == 2'b10)  state <= WRITE;
          else                           state <= READ;
        end
        READ: begin
          if (we_q) begin
            wd_q  <= merged;
            state <= WRITE;
          end else begin
            rdata_q <= load_val;
            state   <= DONE;
          end
        end
        WRITE: state <= DONE;
        DONE:  state <= IDLE;
      endcase
    end
  end

  // Decoded from state so an async reset drops mem_we before any clock edge.
  assign ready        = (state == IDLE);
  assign done         = (state == DONE);
  assign addr_err     = (state == DONE) && err_q;
  assign rdata        = rdata_q;
  assign mem.mem_we   = (state == WRITE);
  assign mem.mem_addr = {addr_q[31:2], 2'b00};
  assign mem.mem_wd   = wd_q;
  assign mem.mem_pc   = pc_q;

endmodule

// File: tb/tb_dm_access_unit.sv
// Directed and randomized checks of dm_access_unit against a byte-array memory model.
module tb_dm_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata, pc;
  logic        ready, done, addr_err;
  logic [31:0] rdata;

  dm_access_unit_if mif ();

  dm_access_unit dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .pc(pc),
    .ready(ready), .done(done), .rdata(rdata), .addr_err(addr_err),
    .mem(mif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem_words [0:63];
  logic [7:0]  ref_mem [0:255];
  logic [31:0] ref_rdata;
  int          we_cnt = 0;
  logic [31:0] last_wa, last_wd, last_pc;

  assign mif.mem_rd = mem_words[mif.mem_addr[7:2]];

  always @(posedge clk) begin
    if (mif.mem_we) begin
      mem_words[mif.mem_addr[7:2]] = mif.mem_wd;
      we_cnt  = we_cnt + 1;
      last_wa = mif.mem_addr;
      last_wd = mif.mem_wd;
      last_pc = mif.mem_pc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [7:0] a);
    logic [7:0] b;
    b = {a[7:2], 2'b00};
    return {ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]};
  endfunction

  task automatic do_op(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] p, input logic intrude);
    int k, nbytes, exp_lat, wc0;
    logic e;
    logic [31:0] v;
    logic [31:0] word20;
    k = 0;
    while (!ready && k < 20) begin @(negedge clk); k++; end
    check("ready_wait", {31'b0, ready}, 32'd1);
    e = (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    nbytes = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    exp_lat = e ? 1 : (!w) ? 2 : (sz == 2'b10) ? 2 : 3;
    word20 = ref_word(8'h20);
    wc0 = we_cnt;
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; pc = p;
    @(negedge clk);
    k = 1;
    if (intrude) begin
      we = 1'b1; size = 2'b10; addr = 32'h20; wdata = 32'hDEADBEEF;
    end else begin
      req = 1'b0;
    end
    while (!done && k < 10) begin @(negedge clk); k++; end
    req = 1'b0;
    check("latency", k, exp_lat);
    check("addr_err", {31'b0, addr_err}, {31'b0, e});
    if (!e && !w) begin
      v = 32'h0;
      for (int i = 0; i < nbytes; i++) v = v | (32'(ref_mem[a[7:0] + 8'(i)]) << (8 * i));
      if (sx && nbytes < 4 && v[8 * nbytes - 1]) v = v | (32'hFFFF_FFFF << (8 * nbytes));
      ref_rdata = v;
    end
    if (!e && w) begin
      for (int i = 0; i < nbytes; i++) ref_mem[a[7:0] + 8'(i)] = wd[8 * i +: 8];
    end
    check("rdata", rdata, ref_rdata);
    check("write_count", we_cnt - wc0, {31'b0, (w && !e)});
    if (w && !e) begin
      check("write_addr", last_wa, {a[31:2], 2'b00});
      check("write_pc", last_pc, p);
    end
    check("mem_word", mem_words[a[7:2]], ref_word(a[7:0]));
    if (intrude) check("busy_word20", mem_words[8], word20);
    @(negedge clk);
    check("done_pulse_width", {31'b0, done}, 32'd0);
  endtask

  initial begin
    logic [31:0] old10;
    int wc0;
    reset = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = 32'h0; wdata = 32'h0; pc = 32'h0; ref_rdata = 32'h0;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] r;
      r = $urandom;
      mem_words[i] = r;
      for (int j = 0; j < 4; j++) ref_mem[4 * i + j] = r[8 * j +: 8];
    end
    @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_addr_err", {31'b0, addr_err}, 32'd0);
    check("rst_mem_we", {31'b0, mif.mem_we}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mif.mem_addr, 32'd0);
    check("rst_mem_wd", mif.mem_wd, 32'd0);
    check("rst_mem_pc", mif.mem_pc, 32'd0);
    reset = 1'b1;

    // word round trip
    do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678, 32'h1000, 1'b0);
    check("sw_wd", last_wd, 32'h12345678);
    check("sw_addr", last_wa, 32'h10);
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1004, 1'b0);
    check("lw_val", rdata, 32'h12345678);

    // byte store and loads
    do_op(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h1008, 1'b0);
    check("sb_word", mem_words[4], 32'h1234AB78);
    do_op(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'h100C, 1'b0);
    check("lb_val", rdata, 32'hFFFFFFAB);
    do_op(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h1010, 1'b0);
    check("lbu_val", rdata, 32'h000000AB);

    // halfword
    do_op(1'b1, 2'b01, 1'b0, 32'h12, 32'h00008001, 32'h1014, 1'b0);
    check("sh_word", mem_words[4], 32'h8001AB78);
    do_op(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h1018, 1'b0);
    check("lh_val", rdata, 32'hFFFF8001);
    do_op(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'h101C, 1'b0);
    check("lhu_val", rdata, 32'h00008001);

    // misalignment and illegal size
    do_op(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 32'h1020, 1'b0);
    do_op(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h1024, 1'b0);
    do_op(1'b0, 2'b11, 1'b1, 32'h10, 32'h0, 32'h1028, 1'b0);
    check("err_rdata_kept", rdata, 32'h00008001);

    // busy: sw @0x20 during the sb's READ cycle must be dropped
    do_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000C3, 32'h102C, 1'b1);

    // reset during the WRITE cycle of a byte store
    old10 = ref_word(8'h10);
    wc0 = we_cnt;
    req = 1'b1; we = 1'b1; size = 2'b00; sign_ext = 1'b0; addr = 32'h10; wdata = 32'h55; pc = 32'h2000;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("rst_mid_we_before", {31'b0, mif.mem_we}, 32'd1);
    #1 reset = 1'b0;
    #1;
    check("rst_mid_mem_we", {31'b0, mif.mem_we}, 32'd0);
    check("rst_mid_ready", {31'b0, ready}, 32'd1);
    check("rst_mid_done", {31'b0, done}, 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    check("rst_mid_mem_addr", mif.mem_addr, 32'd0);
    check("rst_mid_mem_wd", mif.mem_wd, 32'd0);
    check("rst_mid_mem_pc", mif.mem_pc, 32'd0);
    @(negedge clk);
    check("rst_mid_no_done", {31'b0, done}, 32'd0);
    check("rst_mid_no_write", we_cnt - wc0, 32'd0);
    check("rst_mid_word", mem_words[4], old10);
    ref_rdata = 32'h0;
    reset = 1'b1;
    do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h2004, 1'b0);
    check("rst_mid_lw_old", rdata, old10);

    // randomized traffic against the byte-array model
    for (int n = 0; n < 120; n++) begin
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 255)), $urandom, $urandom, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
